fft_peak_reader: RTL

Reads back the FFT magnitude spectrum that the FFT post-processing stage has written into the dual-port spectrum RAM, scanning a configurable bin range once per start request. It tracks the largest magnitude and its bin index, then reports the result with a one-cycle done pulse. The block sits on the RAM read port, between the spectrum RAM and the frequency-measurement/display logic. DC bins are excluded through BIN_START.

---
 rtl/fft_peak_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fft_peak_reader.sv
// fft_peak_reader
//   Scans bins BIN_START..BIN_END of the spectrum RAM once per start request.
//   It returns the largest magnitude and the bin where it was found. Ties keep
//   the lowest bin.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   start, thresh   scan request; thresh is captured when start is accepted
//   rd_addr, q_ram  RAM read port (q_ram is valid RD_LAT clocks after rd_addr)
//   busy, done      busy while scanning; done pulses for one clock with the result
//   peak_bin/mag    result, held until the next scan reports
//   peak_valid      peak_mag >= captured thresh
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | stepping rd_addr BIN_START..BIN_END, one bin per clock
// DRAIN  | waiting for the last read to come back from the RAM
// REPORT | result registers show the new peak, done high
module fft_peak_reader #(
  parameter int ADDR_W    = 13,
  parameter int MAG_W     = 17,
  parameter int BIN_START = 4,
  parameter int BIN_END   = 2047,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MAG_W-1:0]  thresh,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [MAG_W-1:0]  q_ram,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [MAG_W-1:0]  peak_mag,
  output logic              peak_valid
);

  localparam logic [ADDR_W-1:0] LP_BIN_START = ADDR_W'(BIN_START);
  localparam logic [ADDR_W-1:0] LP_BIN_END   = ADDR_W'(BIN_END);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_REPORT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_tag_v    [RD_LAT];
  logic              r_tag_last [RD_LAT];
  logic [ADDR_W-1:0] r_tag_bin  [RD_LAT];

  logic [MAG_W-1:0]  r_thresh;
  logic [MAG_W-1:0]  r_max_mag;
  logic [ADDR_W-1:0] r_max_bin;
  logic              r_have;

  logic              w_accept;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_smp_v;
  logic              w_smp_last;
  logic [ADDR_W-1:0] w_smp_bin;
  logic              w_take;
  logic [MAG_W-1:0]  w_max_mag_nxt;
  logic [ADDR_W-1:0] w_max_bin_nxt;

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_issue      = (r_state == S_ISSUE);
  assign w_last_issue = w_issue && (rd_addr == LP_BIN_END);

  // The oldest tag lines up with the q_ram word for that address.
  assign w_smp_v    = r_tag_v[RD_LAT-1];
  assign w_smp_last = r_tag_last[RD_LAT-1];
  assign w_smp_bin  = r_tag_bin[RD_LAT-1];

  // The first sample of a scan always loads. After that, only a strictly
  // larger sample replaces the max, so ties keep the earlier (lower) bin.
  assign w_take        = w_smp_v && (!r_have || (q_ram > r_max_mag));
  assign w_max_mag_nxt = w_take ? q_ram : r_max_mag;
  assign w_max_bin_nxt = w_take ? w_smp_bin : r_max_bin;

  assign busy = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done = (r_state == S_REPORT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_ISSUE;
      S_ISSUE:  if (rd_addr == LP_BIN_END) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_smp_v && w_smp_last) w_state_nxt = S_REPORT;
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_v[i]    <= 1'b0;
        r_tag_last[i] <= 1'b0;
        r_tag_bin[i]  <= '0;
      end
    end else begin
      r_tag_v[0]    <= w_issue;
      r_tag_last[0] <= w_last_issue;
      r_tag_bin[0]  <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_v[i]    <= r_tag_v[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
        r_tag_bin[i]  <= r_tag_bin[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr    <= '0;
      r_thresh   <= '0;
      r_max_mag  <= '0;
      r_max_bin  <= '0;
      r_have     <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        rd_addr  <= LP_BIN_START;
        r_thresh <= thresh;
      end else if (w_issue && (rd_addr != LP_BIN_END)) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end

      if (w_take) begin
        r_max_mag <= q_ram;
        r_max_bin <= w_smp_bin;
        r_have    <= 1'b1;
      end
      if (w_accept) r_have <= 1'b0;

      // Result registers load on the same edge that enters REPORT, so they
      // include the final sample and change together with done.
      if (w_smp_v && w_smp_last) begin
        peak_bin   <= w_max_bin_nxt;
        peak_mag   <= w_max_mag_nxt;
        peak_valid <= (w_max_mag_nxt >= r_thresh);
      end
    end
  end

endmodule
